// File: rtl/hamming_pkg.sv
// hamming_pkg: FSM states, parity masks and data-to-position map for the (16,11) Hamming encoder.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        OUT_LO,
        OUT_HI
    } state_t;

    localparam int DATA_BITS = 11;
    localparam int CODE_BITS = 16;

    localparam logic [15:0] P1_MASK = 16'hAAA8;
    localparam logic [15:0] P2_MASK = 16'hCCC8;
    localparam logic [15:0] P4_MASK = 16'hF0E0;
    localparam logic [15:0] P8_MASK = 16'hFE00;

    // entry i is the Hamming position of data bit d(i+1)
    localparam logic [10:0][3:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    function automatic logic [15:0] place_data(input logic [10:0] data);
        logic [15:0] body;
        body = '0;
        for (int i = 0; i < DATA_BITS; i++)
            body[DATA_POS[i]] = data[i];
        return body;
    endfunction

endpackage

// File: rtl/hamming_parity.sv
// hamming_parity: maps 11 data bits onto a 16-bit Hamming codeword; c[0] carries overall
// parity only when HAMMING_ENC_P0_EN is defined.
module hamming_parity
    import hamming_pkg::*;
(
    input  logic [10:0] data,
    output logic [15:0] code
);

    logic [15:0] body;
    logic        p1, p2, p4, p8, p0;

    assign body = place_data(data);
    assign p1 = ^(body & P1_MASK);
    assign p2 = ^(body & P2_MASK);
    assign p4 = ^(body & P4_MASK);
    assign p8 = ^(body & P8_MASK);

`ifdef HAMMING_ENC_P0_EN
    // overall parity spans every other codeword bit, parity bits included
    assign p0 = ^body[15:1] ^ p1 ^ p2 ^ p4 ^ p8;
`else
    assign p0 = 1'b0;
`endif

    assign code = body | {7'b0, p8, 3'b0, p4, 1'b0, p2, p1, p0};

endmodule

// File: rtl/hamming_encoder.sv
// hamming_encoder: byte-serial Hamming encoder, two message bytes in, two codeword bytes out.
// Define HAMMING_ENC_P0_EN to put overall (SECDED) parity in c[0].
module hamming_encoder
    import hamming_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] InData,
    input  logic         InValid,
    output logic         InReady,
    output logic [W-1:0] OutData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [7:0]   CwCount
);

    state_t      state;
    logic [7:0]  lo;
    logic [15:0] cw;
    logic [15:0] code;

    hamming_parity u_parity (
        .data ({InData[2:0], lo}),
        .code (code)
    );

    // output byte is selected from the held codeword so it stays stable under backpressure
    assign OutData = state == OUT_LO ? cw[7:0] : state == OUT_HI ? cw[15:8] : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            CwCount  <= '0;
            lo       <= '0;
            cw       <= '0;
        end else begin
            case (state)
                IDLE: if (InValid) begin
                    lo    <= InData;
                    state <= WAIT_HI;
                end
                WAIT_HI: if (InValid) begin
                    cw       <= code;
                    InReady  <= 1'b0;
                    OutValid <= 1'b1;
                    state    <= OUT_LO;
                end
                OUT_LO: if (OutReady)
                    state <= OUT_HI;
                OUT_HI: if (OutReady) begin
                    InReady  <= 1'b1;
                    OutValid <= 1'b0;
                    CwCount  <= CwCount + 8'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder.sv
// tb_hamming_encoder: scoreboard bench; stimulus pushes expected bytes, a monitor pops them on output transfers.
module tb_hamming_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] cw_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];

`ifdef HAMMING_ENC_P0_EN
    localparam logic [7:0] P0 = 8'h01;
`else
    localparam logic [7:0] P0 = 8'h00;
`endif

    // {lo_in, hi_in, lo_out without c0, c0 when enabled, hi_out}
    localparam logic [39:0] VEC [8] = '{
        {8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        {8'h01, 8'h00, 8'h0E, 8'h01, 8'h00},
        {8'hFF, 8'hFF, 8'hFE, 8'h01, 8'hFF},
        {8'h00, 8'h04, 8'h16, 8'h01, 8'h81},
        {8'h02, 8'h00, 8'h32, 8'h01, 8'h00},
        {8'h00, 8'h01, 8'h12, 8'h00, 8'h21},
        {8'h80, 8'h00, 8'h10, 8'h01, 8'h11},
        {8'h00, 8'hFC, 8'h16, 8'h01, 8'h81}
    };

    hamming_encoder #(.W(8)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .InData   (in_data),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .OutData  (out_data),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .CwCount  (cw_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected got=%h", out_data);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (out_data !== e || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL out_byte got=%h in_ready=%b want=%h in_ready=0", out_data, in_ready, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_timeout", 16'(in_ready), 16'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int k);
        logic [39:0] v;
        v = VEC[k];
        q.push_back(v[23:16] | (P0 & v[15:8]));
        q.push_back(v[7:0]);
        send(v[39:32]);
        send(v[31:24]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 16'(q.size()), 16'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data", 16'(out_data), 16'd0);
        check("rst_cw_count", 16'(cw_count), 16'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        send_vec(0);
        drain();
        check("cw_count_first", 16'(cw_count), 16'd1);
        @(posedge clk);
        #2;
        for (int k = 1; k < 8; k++) send_vec(k);
        drain();
        check("cw_count_vectors", 16'(cw_count), 16'd8);

        @(posedge clk);
        #2;
        out_ready = 1'b0;
        send_vec(1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_out_valid", 16'(out_valid), 16'd1);
            check("stall_out_data", 16'(out_data), 16'(8'h0E | P0));
            check("stall_in_ready", 16'(in_ready), 16'd0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check("cw_count_stall", 16'(cw_count), 16'd9);

        @(posedge clk);
        #2;
        send(8'h01);
        pulse_reset();
        @(negedge clk);
        check("midrst_in_ready", 16'(in_ready), 16'd1);
        check("midrst_out_valid", 16'(out_valid), 16'd0);
        check("midrst_cw_count", 16'(cw_count), 16'd0);
        @(posedge clk);
        #2;
        send_vec(0);
        drain();
        check("midrst_cw_count_after", 16'(cw_count), 16'd1);

        pulse_reset();
        for (int i = 0; i < 255; i++) send_vec(i % 8);
        drain();
        check("cw_count_255", 16'(cw_count), 16'd255);
        @(posedge clk);
        #2;
        send_vec(3);
        drain();
        check("cw_count_wrap", 16'(cw_count), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
